// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// Little-endian word/byte lane definitions and the responder state encoding.
package dmem_pkg;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned LANE_W         = $clog2(BYTES_PER_WORD);

    typedef logic [LANE_W-1:0] lane_t;

    localparam lane_t LANE_FIRST = '0;
    localparam lane_t LANE_LAST  = lane_t'(BYTES_PER_WORD - 1);

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StResp
    } state_e;

    // Bit position of the least significant bit of a byte lane within a word.
    function automatic logic [4:0] lane_lsb(lane_t lane);
        return {lane, 3'b000};
    endfunction

endpackage

// File: rtl/dmem_byte_array.sv
// Single-port byte RAM: synchronous write, asynchronous read, no reset.
// Sole holder of the data-memory contents.
module dmem_byte_array
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              CLK,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [BYTE_W-1:0] wdata,
    output logic [BYTE_W-1:0] rdata
);

    logic [BYTE_W-1:0] mem [1 << ADDR_W];

    always_ff @(posedge CLK) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Memory-side end of the load/store interface: one outstanding word request,
// served one byte per cycle from a little-endian byte array, one response each.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W         = 10,
    parameter logic [31:0] RDATA_ON_WRITE = 32'h0
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    // Highest legal word address; 33 bits so the compare never truncates.
    localparam logic [32:0] LAST_WORD_ADDR = 33'((64'd1 << ADDR_W) - 64'd4);

    state_e            state_q, state_d;
    lane_t             byte_cnt_q, byte_cnt_d;
    logic              write_q, write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       asm_q, asm_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;

    logic              req_bad;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [BYTE_W-1:0] mem_wdata;
    logic [BYTE_W-1:0] mem_rdata;

    assign req_bad   = (req_addr[1:0] != 2'b00) || ({1'b0, req_addr} > LAST_WORD_ADDR);
    assign mem_addr  = addr_q + ADDR_W'(byte_cnt_q);
    assign mem_wdata = wdata_q[lane_lsb(byte_cnt_q) +: BYTE_W];
    assign mem_we    = (state_q == StAccess) && write_q;

    assign req_ready = (state_q == StIdle);
    assign rsp_valid = (state_q == StResp);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        write_d    = write_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        asm_d      = asm_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    write_d = req_write;
                    addr_d  = req_addr[ADDR_W-1:0];
                    wdata_d = req_wdata;
                    asm_d   = '0;
                    if (req_bad) begin
                        err_d   = 1'b1;
                        rdata_d = '0;
                        state_d = StResp;
                    end else begin
                        byte_cnt_d = LANE_FIRST;
                        state_d    = StAccess;
                    end
                end
            end
            StAccess: begin
                if (!write_q) begin
                    asm_d[lane_lsb(byte_cnt_q) +: BYTE_W] = mem_rdata;
                end
                byte_cnt_d = byte_cnt_q + lane_t'(1);
                if (byte_cnt_q == LANE_LAST) begin
                    err_d   = 1'b0;
                    rdata_d = write_q ? RDATA_ON_WRITE : asm_d;
                    state_d = StResp;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= StIdle;
            byte_cnt_q <= LANE_FIRST;
            write_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            asm_q      <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            write_q    <= write_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            asm_q      <= asm_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
        end
    end

    dmem_byte_array #(
        .ADDR_W(ADDR_W)
    ) u_mem (
        .CLK  (CLK),
        .we   (mem_we),
        .addr (mem_addr),
        .wdata(mem_wdata),
        .rdata(mem_rdata)
    );

endmodule
